// File: rtl/gzip_frame_ctrl.sv
// gzip_frame_ctrl: sequences one RFC 1952 GZIP member (header, fixed-Huffman deflate body, trailer) per input frame.
// Optional macro GZIP_CRC32_EN builds the CRC32 engine; without it the CRC trailer word is 0x00000000.
module gzip_frame_ctrl #(
  parameter int DRAIN_CYCLES = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  defl_load,
  output logic [DATA_WIDTH-1:0] defl_data,
  output logic                  defl_last,
  input  logic                  lz77_filt_valid,
  input  logic [5:0]            lz77_filt_size,
  input  logic [31:0]           lz77_filt_data,
  input  logic [2:0]            lz77_filt_pad_bits,
  output logic                  out_valid,
  output logic [5:0]            out_size,
  output logic [31:0]           out_data,
  output logic [2:0]            out_pad_bits,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_unexpected
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_MAX = CW'(DRAIN_CYCLES);

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, HDR2, BHDR, STREAM, DRAIN, TRL0, TRL1
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   drain_cnt, drain_cnt_nxt;
  logic [31:0]     isize;
  logic [31:0]     crc_final;
  logic            accept, frame_start, fwd;
  logic            beat_valid;
  logic [5:0]      beat_size;
  logic [31:0]     beat_data;
  logic [2:0]      beat_pad;

  // BHDR's beat is fixed, so the first byte can already be taken there.
  assign in_ready    = (state == BHDR) || (state == STREAM);
  assign accept      = in_valid & in_ready;
  assign frame_start = (state == IDLE) & in_valid;
  assign fwd         = lz77_filt_valid & ((state == STREAM) || (state == DRAIN));

  always_comb begin
    if (lz77_filt_valid)
      drain_cnt_nxt = '0;
    else if (drain_cnt == DRAIN_MAX)
      drain_cnt_nxt = drain_cnt;
    else
      drain_cnt_nxt = drain_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = HDR0;
      HDR0:    state_nxt = HDR1;
      HDR1:    state_nxt = HDR2;
      HDR2:    state_nxt = BHDR;
      BHDR:    state_nxt = (accept && in_last) ? DRAIN : STREAM;
      STREAM:  if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt_nxt == DRAIN_MAX) state_nxt = TRL0;
      TRL0:    state_nxt = TRL1;
      TRL1:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beats are decoded from the state being entered so they register in step with it.
  always_comb begin
    beat_valid = 1'b0;
    beat_size  = '0;
    beat_data  = '0;
    beat_pad   = '0;
    case (state_nxt)
      HDR0: begin beat_valid = 1'b1; beat_size = 6'd32; beat_data = 32'h0008_8B1F; end
      HDR1: begin beat_valid = 1'b1; beat_size = 6'd32; beat_data = 32'h0000_0000; end
      HDR2: begin beat_valid = 1'b1; beat_size = 6'd16; beat_data = 32'h0000_FF00; end
      BHDR: begin beat_valid = 1'b1; beat_size = 6'd3;  beat_data = 32'h0000_0003; end
      TRL0: begin beat_valid = 1'b1; beat_size = 6'd32; beat_data = crc_final;     end
      TRL1: begin beat_valid = 1'b1; beat_size = 6'd32; beat_data = isize;         end
      default: begin
        if (fwd) begin
          beat_valid = 1'b1;
          beat_size  = lz77_filt_size;
          beat_data  = lz77_filt_data;
          beat_pad   = lz77_filt_pad_bits;
        end
      end
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_size     <= '0;
      out_data     <= '0;
      out_pad_bits <= '0;
      defl_load    <= 1'b0;
      defl_data    <= '0;
      defl_last    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      out_valid    <= beat_valid;
      out_size     <= beat_size;
      out_data     <= beat_data;
      out_pad_bits <= beat_pad;
      defl_load    <= accept;
      defl_data    <= accept ? in_data : '0;
      defl_last    <= accept & in_last;
      busy         <= (state_nxt != IDLE);
      frame_done   <= (state_nxt == TRL1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  drain_cnt <= '0;
    else if (state == DRAIN)  drain_cnt <= drain_cnt_nxt;
    else                      drain_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst)              isize <= '0;
    else if (frame_start) isize <= '0;
    else if (accept)      isize <= isize + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)                               err_unexpected <= 1'b0;
    else if (lz77_filt_valid && !fwd)      err_unexpected <= 1'b1;
  end

`ifdef GZIP_CRC32_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in,
                                           input logic [DATA_WIDTH-1:0] d);
    logic [31:0] c;
    c = c_in ^ 32'(d);
    for (int i = 0; i < DATA_WIDTH; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)              crc <= 32'hFFFF_FFFF;
    else if (frame_start) crc <= 32'hFFFF_FFFF;
    else if (accept)      crc <= crc_byte(crc, in_data);
  end

  assign crc_final = ~crc;
`else
  assign crc_final = 32'h0000_0000;
`endif

endmodule

// File: doc/gzip_frame_ctrl.md
# gzip_frame_ctrl

Sequencer wrapping the deflate compressor to produce one complete RFC 1952 GZIP member per input frame. Accepts a byte stream from the Xillybus-side FIFO, emits the GZIP header and fixed-Huffman block header, gates bytes into the deflate core, detects pipeline drain, and appends the CRC32/ISIZE trailer. All output is one bit-chunk stream, 1..32 bits per beat, for the downstream bit packer.

## Interface
- `DRAIN_CYCLES`, 16: consecutive idle cycles of `lz77_filt_valid` after the last byte that mark deflate drained.
- `DATA_WIDTH`, 8: input symbol width; only 8 is supported.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input byte.
- `in_last` in 1: the byte is the last of the frame.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `defl_load` out 1: to deflate `load_data_in`.
- `defl_data` out 8: to deflate `gzip_data_in`.
- `defl_last` out 1: to deflate `gzip_last_symbol`.
- `lz77_filt_valid` in 1, `lz77_filt_size` in 6, `lz77_filt_data` in 32, `lz77_filt_pad_bits` in 3: deflate output.
- `out_valid` out 1, `out_size` out 6 (1..32), `out_data` out 32 (LSB is the first bit): chunk stream.
- `out_pad_bits` out 3: pass-through of `lz77_filt_pad_bits`; 0 on controller-generated beats.
- `busy` out 1: state is not IDLE.
- `frame_done` out 1: one-cycle pulse on the last trailer beat.
- `err_unexpected` out 1: sticky; set by `lz77_filt_valid` while in IDLE, HDRx or TRLx.

## Operation
- States are IDLE, HDR0, HDR1, HDR2, BHDR, STREAM, DRAIN, TRL0, TRL1.
- IDLE: `in_ready`=0. Goes to HDR0 when `in_valid`=1; the byte is held, not consumed.
- HDR0 emits size 32, data 0x00088B1F (ID1, ID2, CM=8, FLG=0).
- HDR1 emits size 32, data 0x00000000 (MTIME).
- HDR2 emits size 16, data 0xFF00 (XFL=0, OS=255).
- BHDR emits size 3, data 3'b011 (BFINAL=1, BTYPE=01). Then goes to STREAM.
- STREAM: `in_ready`=1.
  - Each accepted byte drives `defl_load`=1 and `defl_data`=byte one cycle later.
  - It also updates the CRC and increments ISIZE, a 32-bit counter that wraps mod 2^32.
  - An accepted byte with `in_last`=1 sets `defl_last` with that byte and moves to DRAIN.
- DRAIN: `in_ready`=0.
  - An idle counter clears on every `lz77_filt_valid` and otherwise increments.
  - At `DRAIN_CYCLES` the block goes to TRL0.
- TRL0 emits size 32, data = CRC32. TRL1 emits size 32, data = ISIZE, with `frame_done`=1. Then back to IDLE.
- TRL0/TRL1 assume the deflate stream has already ended byte-aligned, with its EOB code and pad.
- In STREAM and DRAIN, each `lz77_filt_valid` beat is forwarded as one output beat: size, data and pad unchanged.
- Deflate beats seen in any other state are dropped and set `err_unexpected`.
- CRC32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, one byte per cycle. The final value is XORed with 0xFFFFFFFF.
- CRC and ISIZE clear on entry to HDR0.
- Frames are never empty: `in_last` always accompanies a data byte.

## Timing
- Reset values:
  - Outputs: `in_ready`, `defl_load`, `defl_last`, `out_valid`, `busy`, `frame_done`, `err_unexpected` = 0; `defl_data`, `out_size`, `out_data`, `out_pad_bits` = 0.
  - Internal: state IDLE, CRC 0xFFFFFFFF, ISIZE 0, drain counter 0.
- All outputs are registered except `in_ready`, which is decoded combinationally from state.
- Latencies:
  - `in_valid` seen in IDLE at cycle N gives HDR0 on `out_valid` at N+1; HDR1, HDR2, BHDR follow at N+2..N+4.
  - `in_ready` is first high at N+4, so the first byte can be accepted at N+4.
  - Input to `defl_load`: 1 cycle. `lz77_filt_valid` to `out_valid`: 1 cycle.
- The output stream has no backpressure: `out_valid` is asserted whenever a beat exists.
- The deflate core cannot collide with header or trailer beats, because header and trailer occur only while deflate is idle.
- The drain counter saturates at `DRAIN_CYCLES`.
- When reset is asserted mid-frame, the block returns to IDLE next cycle and the partial output is abandoned; the deflate core is reset by its own reset.

## Configuration
- `GZIP_CRC32_EN` defined: the CRC32 engine is built, and TRL0 carries the computed CRC.
- Not defined: no CRC logic is built, and TRL0 carries 0x00000000. All other behaviour and timing are unchanged.

## Test plan
- Reset, then idle: all outputs stay 0 and `busy`=0 for 100 cycles.
- Single byte 0x61 with `in_last`:
  - Beats appear in order: header 0x00088B1F, 0x00000000, 0xFF00/16, 3'b011/3, then the deflate beats.
  - Trailer is 0xE8B7BE43 (CRC "a", with `GZIP_CRC32_EN` defined), then 0x00000001.
  - `frame_done` pulses once.
- "123456789" streamed back-to-back: CRC beat is 0xCBF43926, ISIZE beat is 9; `defl_load` is high for exactly 9 cycles.
- Drain: a deflate beat injected `DRAIN_CYCLES`-1 idle cycles after the last byte restarts the counter; TRL0 appears exactly `DRAIN_CYCLES`+1 cycles after that beat.
- `lz77_filt_valid` forced in IDLE: beat not forwarded, `err_unexpected`=1 until `rst`.
- `rst` asserted during STREAM: the next cycle is IDLE with all outputs 0; a following frame produces a correct header and trailer.
